tdm_demux_1_to_4: RTL and testbench

TDM_DEMUX_1_TO_4 -- requirements
Module: tdm_demux_1_to_4

---
 rtl/tdm_demux_pkg.sv | 19 +
 rtl/tdm_slot_counter.sv | 33 +++
 rtl/tdm_demux_1_to_4.sv | 118 +++++++++++
 tb/tb_tdm_demux_1_to_4.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 1-to-4 TDM demultiplexer.
//   SLOTS     : slots per TDM frame
//   LAST_SLOT : slot index that completes a frame
//   slot_t    : 2-bit slot index
//   state_e   : framing state (hunting for sync / running aligned)
package tdm_demux_pkg;

  localparam int unsigned SLOTS = 4;

  typedef logic [1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);

  typedef enum logic [0:0] {
    StHunt,
    StRun
  } state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-4 slot counter for the TDM demultiplexer.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the counter to slot 0
//   load  : force the counter to slot 1 (the slot after a sync sample)
//   inc   : advance one slot, wrapping 3 -> 0
//   slot  : slot the next accepted sample goes to
// load has priority over inc; with neither asserted the count holds.
module tdm_slot_counter
  import tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  inc,
  output slot_t slot
);

  slot_t slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (load) begin
      slot_q <= slot_t'(1);
    end else if (inc) begin
      slot_q <= slot_q + slot_t'(1);
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux_1_to_4.sv
// 1-to-4 time-division demultiplexer with frame-sync alignment.
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset
//   I, I_valid    : sample stream, one slot per valid cycle
//   frame_sync    : with I_valid, marks the current sample as slot 0
//   Y0..Y3        : registered frame outputs, updated together once per frame
//   Y_valid       : one-cycle pulse when Y0..Y3 carry a new complete frame
//   S1, S0        : slot the next accepted sample will be routed to
//   sync_err      : one-cycle pulse when a sync arrives at a non-zero slot
module tdm_demux_1_to_4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] I,
  input  logic         I_valid,
  input  logic         frame_sync,
  output logic [W-1:0] Y0,
  output logic [W-1:0] Y1,
  output logic [W-1:0] Y2,
  output logic [W-1:0] Y3,
  output logic         Y_valid,
  output logic         S1,
  output logic         S0,
  output logic         sync_err
);

  state_e       state_q;
  slot_t        slot;
  // Slot 3 needs no shadow: it is written straight into Y3 with the frame.
  logic [W-1:0] shadow_q [3];
  logic [W-1:0] y_q [SLOTS];
  logic         y_valid_q;
  logic         sync_err_q;

  logic hunt_sync;
  logic misalign;
  logic cnt_load;
  logic cnt_inc;

  always_comb begin
    hunt_sync = 1'b0;
    misalign  = 1'b0;
    cnt_inc   = 1'b0;
    if (I_valid) begin
      if (state_q == StHunt) begin
        hunt_sync = frame_sync;
      end else begin
        misalign = frame_sync && (slot != '0);
        cnt_inc  = !misalign;
      end
    end
    cnt_load = hunt_sync | misalign;
  end

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .slot  (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      y_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < int'(SLOTS); i++) begin
        y_q[i] <= '0;
      end
    end else begin
      y_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
      unique case (state_q)
        StHunt: begin
          if (hunt_sync) begin
            shadow_q[0] <= I;
            state_q     <= StRun;
          end
        end
        StRun: begin
          if (misalign) begin
            // Drop the partial frame and restart it from this sample.
            shadow_q[0] <= I;
            sync_err_q  <= 1'b1;
          end else if (I_valid) begin
            if (slot == LAST_SLOT) begin
              y_q[0]    <= shadow_q[0];
              y_q[1]    <= shadow_q[1];
              y_q[2]    <= shadow_q[2];
              y_q[3]    <= I;
              y_valid_q <= 1'b1;
            end else begin
              shadow_q[slot] <= I;
            end
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  assign Y0       = y_q[0];
  assign Y1       = y_q[1];
  assign Y2       = y_q[2];
  assign Y3       = y_q[3];
  assign Y_valid  = y_valid_q;
  assign sync_err = sync_err_q;
  assign S1       = slot[1];
  assign S0       = slot[0];

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
module tb_tdm_demux_1_to_4;

  localparam int unsigned W = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] I;
  logic         I_valid;
  logic         frame_sync;
  logic [W-1:0] Y0, Y1, Y2, Y3;
  logic         Y_valid;
  logic         S1, S0;
  logic         sync_err;

  int checks = 0;
  int failures = 0;
  int sync_seen = 0;
  int sync_exp = 0;
  logic [3:0] exp_q [$];

  tdm_demux_1_to_4 #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .I          (I),
    .I_valid    (I_valid),
    .frame_sync (frame_sync),
    .Y0         (Y0),
    .Y1         (Y1),
    .Y2         (Y2),
    .Y3         (Y3),
    .Y_valid    (Y_valid),
    .S1         (S1),
    .S0         (S0),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every Y_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (Y_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_y_valid", 32'(Y_valid), 32'd0);
        end else begin
          check("frame", 32'({Y0, Y1, Y2, Y3}), 32'(exp_q.pop_front()));
        end
      end
      if (sync_err) sync_seen++;
      if (Y_valid || sync_err) begin
        check("pulse_overlap", 32'(Y_valid && sync_err), 32'd0);
      end
    end
  end

  task automatic send(input logic [W-1:0] v, input logic s);
    I          = v;
    I_valid    = 1'b1;
    frame_sync = s;
    @(posedge clk);
    #1;
    I_valid    = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n, input logic [1:0] exp_slot);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check("gap_slot", 32'({S1, S0}), 32'(exp_slot));
      check("gap_no_pulse", 32'(Y_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    I          = '0;
    I_valid    = 1'b0;
    frame_sync = 1'b0;
    #12;
    check("reset_outputs", 32'({Y0, Y1, Y2, Y3, Y_valid, sync_err, S1, S0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_no_pulse", 32'({Y_valid, sync_err}), 32'd0);

    // HUNT discard
    for (int k = 0; k < 5; k++) send(1'b1, 1'b0);
    check("hunt_slot", 32'({S1, S0}), 32'd0);
    check("hunt_y", 32'({Y0, Y1, Y2, Y3}), 32'd0);

    // Aligned frame 1,0,1,0
    exp_q.push_back(4'b1010);
    send(1'b1, 1'b1);
    check("aligned_slot_after_sync", 32'({S1, S0}), 32'd1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    check("aligned_slot_wrap", 32'({S1, S0}), 32'd0);
    check("aligned_y_valid", 32'(Y_valid), 32'd1);
    check("aligned_y", 32'({Y0, Y1, Y2, Y3}), 32'hA);
    @(posedge clk);
    #1;
    check("aligned_pulse_width", 32'(Y_valid), 32'd0);

    // Gapped frame
    exp_q.push_back(4'b1010);
    send(1'b1, 1'b1);
    idle(3, 2'd1);
    send(1'b0, 1'b0);
    idle(3, 2'd2);
    send(1'b1, 1'b0);
    idle(3, 2'd3);
    send(1'b0, 1'b0);
    check("gapped_y_valid", 32'(Y_valid), 32'd1);
    idle(3, 2'd0);
    check("gapped_y_hold", 32'({Y0, Y1, Y2, Y3}), 32'hA);

    // Misalignment: A(sync) B C D(sync)
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    sync_exp++;
    send(1'b0, 1'b1);
    check("misalign_sync_err", 32'(sync_err), 32'd1);
    check("misalign_no_y_valid", 32'(Y_valid), 32'd0);
    check("misalign_slot", 32'({S1, S0}), 32'd1);
    exp_q.push_back(4'b0101);
    send(1'b1, 1'b0);
    check("misalign_err_width", 32'(sync_err), 32'd0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("misalign_y_valid", 32'(Y_valid), 32'd1);
    check("misalign_y", 32'({Y0, Y1, Y2, Y3}), 32'h5);

    // Back-to-back frames 0,1,1,0 then 1,1,0,1
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b1101);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    check("b2b_first_y_valid", 32'(Y_valid), 32'd1);
    send(1'b1, 1'b1);
    check("b2b_no_pulse", 32'({Y_valid, sync_err}), 32'd0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("b2b_second_y_valid", 32'(Y_valid), 32'd1);
    check("b2b_second_y", 32'({Y0, Y1, Y2, Y3}), 32'hD);

    // Mid-frame reset
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({Y0, Y1, Y2, Y3, Y_valid, sync_err, S1, S0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    check("midreset_slot", 32'({S1, S0}), 32'd0);
    idle(4, 2'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("sync_err_count", 32'(sync_seen), 32'(sync_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
